// File: rtl/compare_serial_flags.sv
// compare_serial_flags: chunk-serial A + ~B + c_in (LSB chunk first) with NZCV flags over valid/ready.
// Optional condition-code evaluation (i_cond / o_cond_true) is enabled by defining CMP_COND_EN.
module compare_serial_flags #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_bit1,
  input  logic [WIDTH-1:0] i_bit2,
  input  logic             i_c_in,
`ifdef CMP_COND_EN
  input  logic [3:0]       i_cond,
  output logic             o_cond_true,
`endif
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_n,
  output logic             o_z,
  output logic             o_c,
  output logic             o_v
);

  localparam int NUM_CHUNKS = WIDTH / CHUNK;
  localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_next;
  logic [WIDTH-1:0]   a_sh, b_sh;
  logic               carry, zacc;
  logic [CNT_W-1:0]   cnt;
  logic               accept, handshake, last;
  logic [CHUNK-1:0]   a_ch, nb_ch;
  logic [CHUNK:0]     sum;
  logic               fn, fz, fc, fv;

  assign o_ready   = (state == IDLE) | ((state == DONE) & i_ready);
  assign accept    = i_valid & o_ready;
  assign handshake = (state == DONE) & i_ready;
  assign last      = (state == RUN) && (cnt == CNT_W'(NUM_CHUNKS - 1));

  // Operands shift right each RUN cycle so the active chunk always sits in the low bits.
  always_comb begin
    a_ch  = a_sh[CHUNK-1:0];
    nb_ch = ~b_sh[CHUNK-1:0];
    sum   = {1'b0, a_ch} + {1'b0, nb_ch} + {{CHUNK{1'b0}}, carry};
    fn    = sum[CHUNK-1];
    fc    = sum[CHUNK];
    fz    = zacc & (sum[CHUNK-1:0] == '0);
    fv    = (sum[CHUNK-1] ^ a_ch[CHUNK-1] ^ nb_ch[CHUNK-1]) ^ sum[CHUNK];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (last) state_next = DONE;
      DONE:    if (i_ready) state_next = i_valid ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      carry   <= 1'b0;
      zacc    <= 1'b0;
      cnt     <= '0;
      o_diff  <= '0;
      o_n     <= 1'b0;
      o_z     <= 1'b0;
      o_c     <= 1'b0;
      o_v     <= 1'b0;
      o_valid <= 1'b0;
    end else begin
      if (accept) begin
        a_sh  <= i_bit1;
        b_sh  <= i_bit2;
        carry <= i_c_in;
        zacc  <= 1'b1;
        cnt   <= '0;
      end else if (state == RUN) begin
        a_sh  <= a_sh >> CHUNK;
        b_sh  <= b_sh >> CHUNK;
        carry <= sum[CHUNK];
        zacc  <= fz;
        cnt   <= cnt + CNT_W'(1);
        for (int i = 0; i < NUM_CHUNKS; i++) begin
          if (cnt == CNT_W'(i)) o_diff[i*CHUNK +: CHUNK] <= sum[CHUNK-1:0];
        end
        if (last) begin
          o_n     <= fn;
          o_z     <= fz;
          o_c     <= fc;
          o_v     <= fv;
          o_valid <= 1'b1;
        end
      end
      if (handshake) o_valid <= 1'b0;
    end
  end

`ifdef CMP_COND_EN
  logic [3:0] cond_q;
  logic       cond_hit;

  // Condition is judged on the final-chunk flags so it lands together with o_valid.
  always_comb begin
    cond_hit = 1'b0;
    case (cond_q)
      4'h0: cond_hit = fz;
      4'h1: cond_hit = ~fz;
      4'h2: cond_hit = fc;
      4'h3: cond_hit = ~fc;
      4'h4: cond_hit = fn;
      4'h5: cond_hit = ~fn;
      4'h6: cond_hit = fv;
      4'h7: cond_hit = ~fv;
      4'h8: cond_hit = fc & ~fz;
      4'h9: cond_hit = ~fc | fz;
      4'hA: cond_hit = (fn == fv);
      4'hB: cond_hit = (fn != fv);
      4'hC: cond_hit = ~fz & (fn == fv);
      4'hD: cond_hit = fz | (fn != fv);
      4'hE: cond_hit = 1'b1;
      default: cond_hit = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cond_q      <= '0;
      o_cond_true <= 1'b0;
    end else begin
      if (accept) cond_q <= i_cond;
      if (last) o_cond_true <= cond_hit;
    end
  end
`endif

endmodule

// File: tb/tb_compare_serial_flags.sv
// Bench for compare_serial_flags: three chunkings (8, 32, 4) driven in lockstep and checked every
// cycle against a word-level arithmetic model with a handshake/latency model per instance.
`timescale 1ns/1ps
module tb_compare_serial_flags;
  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] d;
    logic n, z, c, v, t;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_valid = 1'b0;
  logic i_ready = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic c_in = 1'b0;
  logic [3:0] cond = '0;

  logic [2:0] ov, ordy, fn, fz, fc, fv;
  logic [W-1:0] od [3];
`ifdef CMP_COND_EN
  logic [2:0] ct;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  compare_serial_flags #(.WIDTH(W), .CHUNK(8)) u_c8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(ordy[0]),
    .i_bit1(a), .i_bit2(b), .i_c_in(c_in),
`ifdef CMP_COND_EN
    .i_cond(cond), .o_cond_true(ct[0]),
`endif
    .o_valid(ov[0]), .i_ready(i_ready), .o_diff(od[0]),
    .o_n(fn[0]), .o_z(fz[0]), .o_c(fc[0]), .o_v(fv[0]));

  compare_serial_flags #(.WIDTH(W), .CHUNK(32)) u_c32 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(ordy[1]),
    .i_bit1(a), .i_bit2(b), .i_c_in(c_in),
`ifdef CMP_COND_EN
    .i_cond(cond), .o_cond_true(ct[1]),
`endif
    .o_valid(ov[1]), .i_ready(i_ready), .o_diff(od[1]),
    .o_n(fn[1]), .o_z(fz[1]), .o_c(fc[1]), .o_v(fv[1]));

  compare_serial_flags #(.WIDTH(W), .CHUNK(4)) u_c4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(ordy[2]),
    .i_bit1(a), .i_bit2(b), .i_c_in(c_in),
`ifdef CMP_COND_EN
    .i_cond(cond), .o_cond_true(ct[2]),
`endif
    .o_valid(ov[2]), .i_ready(i_ready), .o_diff(od[2]),
    .o_n(fn[2]), .o_z(fz[2]), .o_c(fc[2]), .o_v(fv[2]));

  // Word-level reference: one wide add, overflow from operand/result signs.
  function automatic res_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic cv, input logic [3:0] cc);
    res_t r;
    logic [W:0] w;
    logic [W-1:0] nb;
    nb  = ~bv;
    w   = {1'b0, av} + {1'b0, nb} + {{W{1'b0}}, cv};
    r.d = w[W-1:0];
    r.c = w[W];
    r.n = w[W-1];
    r.z = (w[W-1:0] == '0);
    r.v = (av[W-1] == nb[W-1]) && (w[W-1] != av[W-1]);
    case (cc)
      4'h0: r.t = r.z;
      4'h1: r.t = !r.z;
      4'h2: r.t = r.c;
      4'h3: r.t = !r.c;
      4'h4: r.t = r.n;
      4'h5: r.t = !r.n;
      4'h6: r.t = r.v;
      4'h7: r.t = !r.v;
      4'h8: r.t = r.c && !r.z;
      4'h9: r.t = !r.c || r.z;
      4'hA: r.t = (r.n == r.v);
      4'hB: r.t = (r.n != r.v);
      4'hC: r.t = !r.z && (r.n == r.v);
      4'hD: r.t = r.z || (r.n != r.v);
      4'hE: r.t = 1'b1;
      default: r.t = 1'b0;
    endcase
    return r;
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Per-instance transaction model: busy for NUM_CHUNKS edges, then holds the result until taken.
  int   nch [3] = '{4, 1, 8};
  logic run_m [3] = '{1'b0, 1'b0, 1'b0};
  logic val_m [3] = '{1'b0, 1'b0, 1'b0};
  int   rem [3] = '{0, 0, 0};
  res_t pend [3];
  res_t out_m [3] = '{'0, '0, '0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        run_m[k] = 1'b0;
        val_m[k] = 1'b0;
        rem[k]   = 0;
        out_m[k] = '0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        logic rdy, acc;
        rdy = !run_m[k] && (!val_m[k] || i_ready);
        acc = i_valid && rdy;
        if (val_m[k] && i_ready) val_m[k] = 1'b0;
        if (run_m[k]) begin
          rem[k]--;
          if (rem[k] == 0) begin
            run_m[k] = 1'b0;
            val_m[k] = 1'b1;
            out_m[k] = pend[k];
          end
        end
        if (acc) begin
          run_m[k] = 1'b1;
          rem[k]   = nch[k];
          pend[k]  = model(a, b, c_in, cond);
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      logic rdy_exp;
      rdy_exp = !run_m[k] && (!val_m[k] || i_ready);
      check_output($sformatf("valid[%0d]", k), 64'(ov[k]), 64'(val_m[k]));
      check_output($sformatf("ready[%0d]", k), 64'(ordy[k]), 64'(rdy_exp));
      check_output($sformatf("nzcv[%0d]", k), 64'({fn[k], fz[k], fc[k], fv[k]}),
                   64'({out_m[k].n, out_m[k].z, out_m[k].c, out_m[k].v}));
`ifdef CMP_COND_EN
      check_output($sformatf("cond[%0d]", k), 64'(ct[k]), 64'(out_m[k].t));
`endif
      if (val_m[k]) check_output($sformatf("diff[%0d]", k), 64'(od[k]), 64'(out_m[k].d));
    end
  end

  function automatic logic all_idle();
    for (int k = 0; k < 3; k++) if (run_m[k] || val_m[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic apply_stimulus(input logic [W-1:0] av, input logic [W-1:0] bv,
                                input logic cv, input logic [3:0] cc);
    @(posedge clk); #1;
    a = av; b = bv; c_in = cv; cond = cc;
    i_valid = 1'b1;
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!ov[0] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic directed_op(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                             input logic cv, input logic [3:0] cc,
                             input logic [W-1:0] exp_d, input logic [3:0] exp_nzcv);
    int lat;
    apply_stimulus(av, bv, cv, cc);
    wait_result(lat);
    check_output({name, "_latency"}, 64'(lat), 64'd4);
    check_output({name, "_diff"}, 64'(od[0]), 64'(exp_d));
    check_output({name, "_nzcv"}, 64'({fn[0], fz[0], fc[0], fv[0]}), 64'(exp_nzcv));
`ifdef CMP_COND_EN
    check_output({name, "_cond"}, 64'(ct[0]), 64'(model(av, bv, cv, cc).t));
`endif
    repeat (12) @(posedge clk);
  endtask

  initial begin
    int lat;
    int n;
    res_t r;

    // Hand-computed pins on the reference model itself.
    r = model(32'd5, 32'd5, 1'b1, 4'h0);
    check_output("pin_eq", 64'(r), 64'({32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1}));
    r = model(32'd3, 32'd5, 1'b1, 4'hA);
    check_output("pin_ge", 64'(r), 64'({32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}));
    r = model(32'd3, 32'd5, 1'b1, 4'hB);
    check_output("pin_lt", 64'(r.t), 64'd1);
    r = model(32'h8000_0000, 32'd1, 1'b1, 4'h6);
    check_output("pin_ovf", 64'(r), 64'({32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1}));

    repeat (2) @(posedge clk); #1;
    check_output("rst_valid", 64'(ov[0]), 64'd0);
    check_output("rst_diff", 64'(od[0]), 64'd0);
    check_output("rst_flags", 64'({fn[0], fz[0], fc[0], fv[0]}), 64'd0);
    check_output("rst_ready", 64'(ordy[0]), 64'd1);
    rst_n = 1'b1;

    directed_op("eq",   32'd5, 32'd5, 1'b1, 4'hE, 32'h0000_0000, 4'b0110);
    directed_op("ge",   32'd3, 32'd5, 1'b1, 4'hA, 32'hFFFF_FFFE, 4'b1000);
    directed_op("lt",   32'd3, 32'd5, 1'b1, 4'hB, 32'hFFFF_FFFE, 4'b1000);
    directed_op("ovf1", 32'h8000_0000, 32'd1, 1'b1, 4'h6, 32'h7FFF_FFFF, 4'b0011);
    directed_op("ovf2", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 4'hC, 32'h8000_0000, 4'b1001);

    // Back-pressure in DONE with a pending request, then back-to-back accept on release.
    apply_stimulus(32'd10, 32'd3, 1'b1, 4'h2);
    a = 32'd1; b = 32'd1; c_in = 1'b1; cond = 4'h0;
    i_valid = 1'b1;
    i_ready = 1'b0;
    wait_result(lat);
    check_output("bp_latency", 64'(lat), 64'd4);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_output("bp_valid_hold", 64'(ov[0]), 64'd1);
      check_output("bp_diff_hold", 64'(od[0]), 64'd7);
      check_output("bp_flags_hold", 64'({fn[0], fz[0], fc[0], fv[0]}), 64'b0010);
      check_output("bp_ready_low", 64'(ordy[0]), 64'd0);
    end
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    check_output("b2b_valid_drop", 64'(ov[0]), 64'd0);
    wait_result(lat);
    check_output("b2b_latency", 64'(lat), 64'd4);
    check_output("b2b_diff", 64'(od[0]), 64'd0);
    check_output("b2b_flags", 64'({fn[0], fz[0], fc[0], fv[0]}), 64'b0110);
    repeat (12) @(posedge clk);

    // Reset in the middle of RUN (chunk count 2 on the CHUNK=8 instance).
    apply_stimulus(32'd9, 32'd2, 1'b1, 4'h1);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_output("mid_rst_valid", 64'(ov[0]), 64'd0);
    check_output("mid_rst_diff", 64'(od[0]), 64'd0);
    check_output("mid_rst_flags", 64'({fn[0], fz[0], fc[0], fv[0]}), 64'd0);
    check_output("mid_rst_ready", 64'(ordy[0]), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    directed_op("post_rst", 32'd5, 32'd5, 1'b1, 4'h0, 32'h0000_0000, 4'b0110);

    // Randomized operations with random consumer back-pressure.
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      a    = $urandom;
      b    = ($urandom_range(0, 7) == 0) ? a : $urandom;
      c_in = 1'($urandom_range(0, 1));
      cond = 4'($urandom_range(0, 15));
      i_valid = 1'b1;
      i_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      i_valid = 1'b0;
      n = 0;
      while (!all_idle() && n < 60) begin
        i_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        n++;
      end
      if (!all_idle()) check_output("rand_idle_timeout", 64'(n), 64'd60 - 64'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
